// File: rtl/formula_result_buffer.sv
// Credit-controlled result FIFO: launches are admitted only while a slot is
// guaranteed for their result, so the non-stallable result stream never overflows.
module formula_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arg_vld,
  output logic                     arg_rdy,
  input  logic                     res_vld,
  input  logic [WIDTH-1:0]         res,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W:0]   credit_used;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             write;

  // Extra bit: error pushes can let inflight+count exceed DEPTH.
  assign credit_used = {1'b0, inflight} + {1'b0, count};
  assign arg_rdy     = !rst && (credit_used < {1'b0, DEPTH_C});

  assign accept   = arg_vld & arg_rdy;
  assign push     = res_vld;
  assign out_vld  = (count != '0);
  assign pop      = out_vld & out_rdy;
  assign full     = (count == DEPTH_C);
  assign write    = push & (!full | pop);
  assign out_data = out_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      if (accept && !push)
        inflight <= inflight + CNT_W'(1);
      else if (push && !accept && inflight != '0)
        inflight <= inflight - CNT_W'(1);

      if (write)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);

      if (write && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !write)
        count <= count - CNT_W'(1);

      // Unsolicited result or dropped result both latch the error.
      if (push && (!write || inflight == '0))
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write)
      mem[wr_ptr] <= res;
  end

endmodule

// File: tb/tb_formula_result_buffer.sv
// Scoreboard bench for formula_result_buffer at DEPTH=4, WIDTH=32.
module tb_formula_result_buffer;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arg_vld = 1'b0;
  logic          arg_rdy;
  logic          res_vld = 1'b0;
  logic [W-1:0]  res = '0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [W-1:0]  out_data;
  logic [2:0]    count;
  logic          err;

  int total = 0;
  int bad = 0;
  int pops = 0;
  logic [W-1:0] sb [$];

  formula_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .res_vld(res_vld), .res(res), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output beat is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_vld && out_rdy) begin
      pops++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got 0x%0h expected nothing", out_data);
      end else begin
        chk("out_order", out_data, sb.pop_front());
      end
    end
  end

  task automatic drive(input logic av, input logic rv, input logic [W-1:0] r, input logic ordy);
    arg_vld = av;
    res_vld = rv;
    res     = r;
    out_rdy = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic av, input logic rv, input logic [W-1:0] r, input logic ordy);
    drive(av, rv, r, ordy);
    tick();
  endtask

  task automatic do_reset();
    drive(0, 0, '0, 0);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic          pv [16];
  logic [W-1:0]  pd [16];
  int            accepted;
  int            pops_base;
  int            max_cnt;
  logic          acc;
  logic [W-1:0]  next_val;

  initial begin
    // Reset values
    tick();
    chk("rst_arg_rdy", {31'd0, arg_rdy}, 0);
    chk("rst_out_vld", {31'd0, out_vld}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_arg_rdy", {31'd0, arg_rdy}, 1);

    // Credit stall
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0);
    chk("stall_rdy_after3", {31'd0, arg_rdy}, 1);
    cyc(1, 0, '0, 0);
    chk("stall_rdy_after4", {31'd0, arg_rdy}, 0);
    cyc(1, 0, '0, 0);
    chk("stall_rdy_after5", {31'd0, arg_rdy}, 0);
    chk("stall_count", {29'd0, count}, 0);
    chk("stall_err", {31'd0, err}, 0);

    // Ordering, 1-cycle latency, no bypass
    drive(0, 1, 32'h11, 1);
    sb.push_back(32'h11);
    #1;
    chk("no_bypass_vld", {31'd0, out_vld}, 0);
    tick();
    chk("lat_vld", {31'd0, out_vld}, 1);
    chk("lat_data", out_data, 32'h11);
    cyc(0, 1, 32'h22, 1); sb.push_back(32'h22);
    cyc(0, 1, 32'h33, 1); sb.push_back(32'h33);
    cyc(0, 1, 32'h44, 1); sb.push_back(32'h44);
    chk("order_count_mid", {29'd0, count}, 1);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    chk("order_count_end", {29'd0, count}, 0);
    chk("order_data_empty", out_data, 0);
    chk("order_rdy", {31'd0, arg_rdy}, 1);
    chk("order_err", {31'd0, err}, 0);

    // Full, then pop raises credit only on the following cycle
    for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 32'hA0 + 32'(i), 0);
      sb.push_back(32'hA0 + 32'(i));
    end
    chk("full_count", {29'd0, count}, 4);
    chk("full_rdy", {31'd0, arg_rdy}, 0);
    drive(1, 0, '0, 1);
    #1;
    chk("pop_cycle_rdy", {31'd0, arg_rdy}, 0);
    tick();
    chk("after_pop_rdy", {31'd0, arg_rdy}, 1);
    chk("after_pop_count", {29'd0, count}, 3);
    cyc(1, 0, '0, 0);
    chk("sum4_rdy", {31'd0, arg_rdy}, 0);
    cyc(0, 1, 32'hA4, 1); sb.push_back(32'hA4);
    chk("pushpop_count", {29'd0, count}, 3);
    chk("pushpop_err", {31'd0, err}, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1);
    chk("full_drain_count", {29'd0, count}, 0);

    // Unsolicited result: error but data kept
    cyc(0, 1, 32'hDEADBEEF, 0); sb.push_back(32'hDEADBEEF);
    chk("unsol_err", {31'd0, err}, 1);
    chk("unsol_vld", {31'd0, out_vld}, 1);
    chk("unsol_data", out_data, 32'hDEADBEEF);
    cyc(0, 0, '0, 0);
    chk("unsol_err_sticky", {31'd0, err}, 1);
    cyc(0, 0, '0, 1);
    chk("unsol_count", {29'd0, count}, 0);

    // Overflow: fifth push into a full FIFO is dropped
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 32'hC0 + 32'(i), 0);
      if (i < 4) sb.push_back(32'hC0 + 32'(i));
    end
    chk("ovf_count", {29'd0, count}, 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    chk("ovf_drain_count", {29'd0, count}, 0);
    chk("ovf_inflight_zero_rdy", {31'd0, arg_rdy}, 1);
    chk("ovf_err", {31'd0, err}, 1);

    // Reset mid-run: 2 stored, 2 in flight
    for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0);
    cyc(0, 1, 32'hB0, 0); sb.push_back(32'hB0);
    cyc(0, 1, 32'hB1, 0); sb.push_back(32'hB1);
    chk("pre_rst_count", {29'd0, count}, 2);
    rst = 1'b1;
    #1;
    chk("async_rst_vld", {31'd0, out_vld}, 0);
    chk("async_rst_count", {29'd0, count}, 0);
    chk("async_rst_rdy", {31'd0, arg_rdy}, 0);
    chk("async_rst_err", {31'd0, err}, 0);
    chk("async_rst_data", out_data, 0);
    do_reset();
    chk("rel_rdy", {31'd0, arg_rdy}, 1);
    chk("rel_count", {29'd0, count}, 0);
    cyc(0, 1, 32'h55, 0); sb.push_back(32'h55);
    chk("late_err", {31'd0, err}, 1);
    chk("late_count", {29'd0, count}, 1);
    chk("late_data", out_data, 32'h55);
    cyc(0, 0, '0, 1);
    do_reset();
    chk("rst2_err", {31'd0, err}, 0);

    // Throughput with a 16-cycle result pipeline
    for (int i = 0; i < 16; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    accepted = 0;
    pops_base = pops;
    max_cnt = 0;
    next_val = 32'h1000;
    for (int c = 0; c < 80; c++) begin
      drive(c < 50, pv[15], pd[15], 1);
      if (pv[15]) sb.push_back(pd[15]);
      acc = (c < 50) && arg_rdy;
      for (int i = 15; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = acc;
      pd[0] = next_val;
      if (acc) begin accepted++; next_val++; end
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    cyc(0, 0, '0, 0);
    chk("tput_err", {31'd0, err}, 0);
    chk("tput_max_count_le2", {31'd0, max_cnt <= 2}, 1);
    chk("tput_results", 32'(pops - pops_base), 32'(accepted));
    chk("tput_count_end", {29'd0, count}, 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
